// File: rtl/ds_link_rx_if.sv
// DS-link receive-side bundle: the Data/Strobe pins and the decoded character outputs.
// The receiver drives the outputs through the master modport; the link controller uses slave.
interface ds_link_rx_if;
    logic       D_in;
    logic       S_in;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_eop;
    logic       rx_eep;
    logic       rx_fct;
    logic       rx_null;
    logic       link_up;
    logic       err_parity;
    logic       err_esc;
    logic       err_disc;

    modport master (
        input  D_in, S_in,
        output rx_data, rx_data_valid, rx_eop, rx_eep, rx_fct, rx_null,
        output link_up, err_parity, err_esc, err_disc
    );

    modport slave (
        output D_in, S_in,
        input  rx_data, rx_data_valid, rx_eop, rx_eep, rx_fct, rx_null,
        input  link_up, err_parity, err_esc, err_disc
    );
endinterface

// File: rtl/ds_link_rx.sv
// IEEE1355 DS-link character receiver: recovers bits from D^S transitions, locks on NULL,
// decodes data/control characters and flags parity, escape and disconnect errors.
module ds_link_rx #(
    parameter bit G_LINK_PARITY_IS_ODD = 1'b1,
    parameter int G_DISC_CYCLES        = 85
) (
    input logic          CLK100MHZ,
    input logic          rst,
    ds_link_rx_if.master link
);
    localparam int              C_CW        = $clog2(G_DISC_CYCLES + 1);
    localparam logic [C_CW-1:0] C_DISC_LAST = C_CW'(G_DISC_CYCLES - 1);
    localparam logic [6:0]      C_NULL_TAIL = {3'b111, ~G_LINK_PARITY_IS_ODD, 3'b100};

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_ESC_WAIT = 2'd2
    } state_t;

    function automatic logic f_parity_ok(input logic prev_par, input logic p, input logic f);
        return (prev_par ^ p ^ f) == G_LINK_PARITY_IS_ODD;
    endfunction

    logic       r_d1, r_d2, r_s1, r_s2, r_x_prev;
    logic       r_evt, r_bit;
    state_t     r_state, w_state_n;
    logic [6:0] r_hunt, w_hunt_n;
    logic [9:0] r_char, w_char_n, w_cur;
    logic [3:0] r_bit_cnt, w_bit_cnt_n;
    logic       r_prev_par, w_prev_par_n;
    logic [C_CW-1:0] r_disc_cnt;
    logic       r_armed;
    logic       w_x, w_done, w_par_ok, w_char_par, w_disc_hit;
    logic [1:0] w_ctrl;

    logic [7:0] r_rx_data, w_rx_data_n;
    logic       r_rx_data_valid, r_rx_eop, r_rx_eep, r_rx_fct, r_rx_null, r_link_up;
    logic       r_err_parity, r_err_esc, r_err_disc;
    logic       w_rx_data_valid_n, w_rx_eop_n, w_rx_eep_n, w_rx_fct_n, w_rx_null_n, w_link_up_n;
    logic       w_err_parity_n, w_err_esc_n, w_err_disc_n;

    assign w_x        = r_d2 ^ r_s2;
    assign w_disc_hit = r_armed && !r_evt && (r_disc_cnt == C_DISC_LAST);

    // Synchronizers and previous-x register run freely so reset never fakes a bit event.
    always_ff @(posedge CLK100MHZ) begin
        r_d1     <= link.D_in;
        r_d2     <= r_d1;
        r_s1     <= link.S_in;
        r_s2     <= r_s1;
        r_x_prev <= w_x;
    end

    // Registered bit event; the character logic consumes it one cycle later.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_evt <= 1'b0;
            r_bit <= 1'b0;
        end else begin
            r_evt <= w_x ^ r_x_prev;
            r_bit <= r_d2;
        end
    end

    // Disconnect timer: cleared by bit events, armed by the first one, saturates on expiry.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_disc_cnt <= '0;
            r_armed    <= 1'b0;
        end else if (r_evt) begin
            r_disc_cnt <= '0;
            r_armed    <= 1'b1;
        end else if (r_armed) begin
            r_disc_cnt <= r_disc_cnt + C_CW'(1);
            r_armed    <= (r_disc_cnt != C_DISC_LAST);
        end else begin
            r_disc_cnt <= r_disc_cnt;
            r_armed    <= 1'b0;
        end
    end

    // Next-state and output decode for character assembly.
    always_comb begin
        w_state_n         = r_state;
        w_hunt_n          = r_hunt;
        w_char_n          = r_char;
        w_bit_cnt_n       = r_bit_cnt;
        w_prev_par_n      = r_prev_par;
        w_rx_data_n       = r_rx_data;
        w_link_up_n       = r_link_up;
        w_rx_data_valid_n = 1'b0;
        w_rx_eop_n        = 1'b0;
        w_rx_eep_n        = 1'b0;
        w_rx_fct_n        = 1'b0;
        w_rx_null_n       = 1'b0;
        w_err_parity_n    = 1'b0;
        w_err_esc_n       = 1'b0;
        w_err_disc_n      = 1'b0;

        w_cur            = r_char;
        w_cur[r_bit_cnt] = r_bit;
        w_done     = (r_bit_cnt == 4'd9) || ((r_bit_cnt == 4'd3) && w_cur[1]);
        w_par_ok   = f_parity_ok(r_prev_par, w_cur[0], w_cur[1]);
        w_ctrl     = {w_cur[2], w_cur[3]};
        w_char_par = w_cur[1] ? ^w_ctrl : ^w_cur[9:2];

        case (r_state)
            ST_HUNT: begin
                if (r_evt) begin
                    w_hunt_n = {r_hunt[5:0], r_bit};
                    if (w_hunt_n == C_NULL_TAIL) begin
                        w_rx_null_n  = 1'b1;
                        w_link_up_n  = 1'b1;
                        w_state_n    = ST_RUN;
                        w_hunt_n     = 7'd0;
                        w_char_n     = 10'd0;
                        w_bit_cnt_n  = 4'd0;
                        w_prev_par_n = 1'b0;
                    end else begin
                        w_state_n = ST_HUNT;
                    end
                end else begin
                    w_state_n = ST_HUNT;
                end
            end
            ST_RUN, ST_ESC_WAIT: begin
                if (r_evt && !w_done) begin
                    w_char_n    = w_cur;
                    w_bit_cnt_n = r_bit_cnt + 4'd1;
                end else if (r_evt) begin
                    w_char_n    = 10'd0;
                    w_bit_cnt_n = 4'd0;
                    if (!w_par_ok) begin
                        w_err_parity_n = 1'b1;
                        w_link_up_n    = 1'b0;
                        w_state_n      = ST_HUNT;
                        w_hunt_n       = 7'd0;
                    end else if (r_state == ST_ESC_WAIT) begin
                        w_prev_par_n = w_char_par;
                        if (w_cur[1] && (w_ctrl == 2'b00)) begin
                            w_rx_null_n = 1'b1;
                            w_state_n   = ST_RUN;
                        end else begin
                            w_err_esc_n = 1'b1;
                            w_link_up_n = 1'b0;
                            w_state_n   = ST_HUNT;
                            w_hunt_n    = 7'd0;
                        end
                    end else if (!w_cur[1]) begin
                        w_prev_par_n      = w_char_par;
                        w_rx_data_n       = w_cur[9:2];
                        w_rx_data_valid_n = 1'b1;
                    end else begin
                        w_prev_par_n = w_char_par;
                        case (w_ctrl)
                            2'b00:   w_rx_fct_n = 1'b1;
                            2'b01:   w_rx_eop_n = 1'b1;
                            2'b10:   w_rx_eep_n = 1'b1;
                            2'b11:   w_state_n  = ST_ESC_WAIT;
                            default: w_state_n  = ST_HUNT;
                        endcase
                    end
                end else begin
                    w_state_n = r_state;
                end
            end
            default: begin
                w_state_n = ST_HUNT;
                w_hunt_n  = 7'd0;
            end
        endcase

        // A disconnect overrides anything decoded in the same cycle.
        if (w_disc_hit) begin
            w_err_disc_n      = 1'b1;
            w_err_parity_n    = 1'b0;
            w_err_esc_n       = 1'b0;
            w_rx_data_valid_n = 1'b0;
            w_rx_eop_n        = 1'b0;
            w_rx_eep_n        = 1'b0;
            w_rx_fct_n        = 1'b0;
            w_rx_null_n       = 1'b0;
            w_link_up_n       = 1'b0;
            w_state_n         = ST_HUNT;
            w_hunt_n          = 7'd0;
            w_char_n          = 10'd0;
            w_bit_cnt_n       = 4'd0;
        end else begin
            w_err_disc_n = 1'b0;
        end
    end

    // Character state and registered outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_state         <= ST_HUNT;
            r_hunt          <= 7'd0;
            r_char          <= 10'd0;
            r_bit_cnt       <= 4'd0;
            r_prev_par      <= 1'b0;
            r_rx_data       <= 8'h00;
            r_rx_data_valid <= 1'b0;
            r_rx_eop        <= 1'b0;
            r_rx_eep        <= 1'b0;
            r_rx_fct        <= 1'b0;
            r_rx_null       <= 1'b0;
            r_link_up       <= 1'b0;
            r_err_parity    <= 1'b0;
            r_err_esc       <= 1'b0;
            r_err_disc      <= 1'b0;
        end else begin
            r_state         <= w_state_n;
            r_hunt          <= w_hunt_n;
            r_char          <= w_char_n;
            r_bit_cnt       <= w_bit_cnt_n;
            r_prev_par      <= w_prev_par_n;
            r_rx_data       <= w_rx_data_n;
            r_rx_data_valid <= w_rx_data_valid_n;
            r_rx_eop        <= w_rx_eop_n;
            r_rx_eep        <= w_rx_eep_n;
            r_rx_fct        <= w_rx_fct_n;
            r_rx_null       <= w_rx_null_n;
            r_link_up       <= w_link_up_n;
            r_err_parity    <= w_err_parity_n;
            r_err_esc       <= w_err_esc_n;
            r_err_disc      <= w_err_disc_n;
        end
    end

    assign link.rx_data       = r_rx_data;
    assign link.rx_data_valid = r_rx_data_valid;
    assign link.rx_eop        = r_rx_eop;
    assign link.rx_eep        = r_rx_eep;
    assign link.rx_fct        = r_rx_fct;
    assign link.rx_null       = r_rx_null;
    assign link.link_up       = r_link_up;
    assign link.err_parity    = r_err_parity;
    assign link.err_esc       = r_err_esc;
    assign link.err_disc      = r_err_disc;
endmodule
